// File: rtl/scan_seq_ctrl.sv
// Scan sequencer: rotate stage through N_POS positions, settle, then walk enabled RF channels with one ADC window each.
// Optional rotation watchdog is built when CMB_SEQ_WDOG_EN is defined.
module scan_seq_ctrl #(
   parameter int unsigned N_POS         = 400,
   parameter int unsigned STEPS_PER_POS = 8,
   parameter int unsigned SETTLE_CYC    = 50000,
   parameter int unsigned SW_CYC        = 500,
   parameter int unsigned ADC_CYC       = 1000,
   parameter int unsigned WDOG_CYC      = 2000000
) (
   input  logic       clk50,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       stp_tick,
   input  logic [3:0] rf_mask,
   output logic       rot_en,
   output logic [3:0] rf_sw,
   output logic       adc_en,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [9:0] pos_count
);

   localparam int unsigned POS_W = 10;
   localparam int unsigned STP_W = 8;
   localparam int unsigned CH_W  = 2;
   localparam int unsigned MAX_A = (SETTLE_CYC > SW_CYC) ? SETTLE_CYC : SW_CYC;
   localparam int unsigned MAX_B = (MAX_A > ADC_CYC) ? MAX_A : ADC_CYC;
`ifdef CMB_SEQ_WDOG_EN
   localparam int unsigned CNT_MAX = (MAX_B > WDOG_CYC) ? MAX_B : WDOG_CYC;
`else
   localparam int unsigned CNT_MAX = MAX_B;
`endif
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_RF_SEL, S_ACQ, S_ROTATE, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STP_W-1:0]   tick_q, tick_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [3:0]         mask_q, mask_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic               rot_en_q, rot_en_d;
   logic [3:0]         rf_sw_q, rf_sw_d;
   logic               adc_en_q, adc_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               fault_q, fault_d;

   logic [CH_W-1:0]    first_ch_c;
   logic [CH_W-1:0]    next_ch_c;
   logic               next_vld_c;

   // Lowest enabled channel, and lowest enabled channel above the current one.
   always_comb begin
      first_ch_c = '0;
      next_ch_c  = '0;
      next_vld_c = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (mask_q[i]) begin
            first_ch_c = CH_W'(i);
            if (i > int'(ch_q)) begin
               next_ch_c  = CH_W'(i);
               next_vld_c = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tick_q   <= '0;
         pos_q    <= '0;
         mask_q   <= '0;
         ch_q     <= '0;
         rot_en_q <= 1'b0;
         rf_sw_q  <= '0;
         adc_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         pos_q    <= pos_d;
         mask_q   <= mask_d;
         ch_q     <= ch_d;
         rot_en_q <= rot_en_d;
         rf_sw_q  <= rf_sw_d;
         adc_en_q <= adc_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
      end
   end

   // Next state; outputs are decoded from the next state so they register with it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      tick_d  = tick_q;
      pos_d   = pos_q;
      mask_d  = mask_q;
      ch_d    = ch_q;
      fault_d = fault_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start && (rf_mask != 4'd0)) begin
               mask_d  = rf_mask;
               pos_d   = '0;
               fault_d = 1'b0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               ch_d    = first_ch_c;
               state_d = S_RF_SEL;
            end
         end
         S_RF_SEL: begin
            if (cnt_q == CNT_W'(SW_CYC - 1)) begin
               state_d = S_ACQ;
            end
         end
         S_ACQ: begin
            if (cnt_q == CNT_W'(ADC_CYC - 1)) begin
               if (next_vld_c) begin
                  ch_d    = next_ch_c;
                  state_d = S_RF_SEL;
               end else if (pos_q == POS_W'(N_POS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ROTATE;
               end
            end
         end
         S_ROTATE: begin
`ifdef CMB_SEQ_WDOG_EN
            // Cycle counter doubles as the stall watchdog, cleared by every step.
            if (stp_tick) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(WDOG_CYC - 1)) begin
               fault_d = 1'b1;
               state_d = S_IDLE;
            end
`else
            cnt_d = '0;
`endif
            if (stp_tick) begin
               if (tick_q == STP_W'(STEPS_PER_POS - 1)) begin
                  pos_d   = pos_q + POS_W'(1);
                  state_d = S_SETTLE;
               end else begin
                  tick_d = tick_q + STP_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over anything else happening this cycle.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         pos_d   = pos_q;
         fault_d = fault_q;
      end

      if (state_d != state_q) begin
         cnt_d  = '0;
         tick_d = '0;
      end

      rot_en_d = (state_d == S_ROTATE);
      rf_sw_d  = ((state_d == S_RF_SEL) || (state_d == S_ACQ)) ? (4'd1 << ch_d) : 4'd0;
      adc_en_d = (state_d == S_ACQ);
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
   end

   assign rot_en    = rot_en_q;
   assign rf_sw     = rf_sw_q;
   assign adc_en    = adc_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pos_count = pos_q;
`ifdef CMB_SEQ_WDOG_EN
   assign fault     = fault_q;
`else
   assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed self-checking bench for scan_seq_ctrl using hand-derived cycle timelines.
module tb_scan_seq_ctrl;

   logic       clk50;
   logic       rst;
   logic       start;
   logic       abort;
   logic       stp_tick;
   logic [3:0] rf_mask;
   logic       rot_en;
   logic [3:0] rf_sw;
   logic       adc_en;
   logic       busy;
   logic       done;
   logic       fault;
   logic [9:0] pos_count;

   int n_cmp = 0;
   int n_err = 0;

   scan_seq_ctrl #(
      .N_POS        (3),
      .STEPS_PER_POS(2),
      .SETTLE_CYC   (4),
      .SW_CYC       (2),
      .ADC_CYC      (3),
      .WDOG_CYC     (20)
   ) dut (
      .clk50    (clk50),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .stp_tick (stp_tick),
      .rf_mask  (rf_mask),
      .rot_en   (rot_en),
      .rf_sw    (rf_sw),
      .adc_en   (adc_en),
      .busy     (busy),
      .done     (done),
      .fault    (fault),
      .pos_count(pos_count)
   );

   initial begin
      clk50 = 1'b0;
      forever #5 clk50 = ~clk50;
   end

   // {rot_en, rf_sw, adc_en, busy, done, fault, pos_count}
   logic [18:0] obs;
   assign obs = {rot_en, rf_sw, adc_en, busy, done, fault, pos_count};

   localparam logic [18:0] IDLE_P0 = 19'd0;

   function automatic logic [18:0] idle_at(input int pos, input logic flt);
      return {1'b0, 4'd0, 1'b0, 1'b0, 1'b0, flt, 10'(pos)};
   endfunction

   // Expected outputs after edge k of a scan started at edge 1, ticks on every 5th edge.
   // mode 0: mask 0101, positions start at edges 1/25/45.
   // mode 1: mask 1000, mode 2: mask 0001; positions start at edges 1/20/35.
   function automatic logic [18:0] exp_at(input int mode, input int k);
      int s0, s1, s2, p, rel, nch, fin;
      logic [3:0] c0, c1, rf;
      logic rot, adc, bsy, dn;
      s0  = 1;
      s1  = (mode == 0) ? 25 : 20;
      s2  = (mode == 0) ? 45 : 35;
      nch = (mode == 0) ? 2 : 1;
      c0  = (mode == 0) ? 4'b0001 : ((mode == 1) ? 4'b1000 : 4'b0001);
      c1  = 4'b0100;
      fin = 4 + 5 * nch;
      p   = (k >= s2) ? 2 : ((k >= s1) ? 1 : 0);
      rel = k - ((p == 2) ? s2 : ((p == 1) ? s1 : s0));
      rot = 1'b0; rf = 4'd0; adc = 1'b0; bsy = 1'b1; dn = 1'b0;
      if (rel >= fin) begin
         if (p < 2) rot = 1'b1;
         else if (rel == fin) dn = 1'b1;
         else bsy = 1'b0;
      end else if (rel >= 4) begin
         rf  = (rel < 9) ? c0 : c1;
         adc = ((rel - 4) % 5) >= 2;
      end
      return {rot, rf, adc, bsy, dn, 1'b0, 10'(p)};
   endfunction

   task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic chk_int(input string tag, input int o, input int e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk50);
      #1;
   endtask

   int   acq_n;
   int   done_n;
   logic adc_prev;

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      stp_tick = 1'b0;
      rf_mask  = 4'd0;
      #1 rst = 1'b1;
      #2;
      chk("reset_state", obs, IDLE_P0);
      step();
      step();
      chk("reset_held", obs, IDLE_P0);
      @(negedge clk50);
      rst = 1'b0;
      step();
      chk("idle_after_release", obs, IDLE_P0);

      // Full scan with stray starts during the scan.
      rf_mask  = 4'b0101;
      acq_n    = 0;
      done_n   = 0;
      adc_prev = 1'b0;
      for (int k = 1; k <= 62; k++) begin
         start    = (k == 1) || (k == 12) || (k == 20) || (k == 30);
         stp_tick = (k % 5 == 0);
         step();
         chk($sformatf("full k=%0d", k), obs, exp_at(0, k));
         if (adc_en && !adc_prev) acq_n++;
         if (done) done_n++;
         adc_prev = adc_en;
      end
      start    = 1'b0;
      stp_tick = 1'b0;
      chk_int("acq_windows", acq_n, 6);
      chk_int("done_pulses", done_n, 1);

      // Start with an empty mask is ignored.
      rf_mask = 4'd0;
      start   = 1'b1;
      step();
      start = 1'b0;
      chk("zero_mask_start", obs, idle_at(2, 1'b0));
      step();
      step();
      chk("zero_mask_later", obs, idle_at(2, 1'b0));

      // Abort on the last ACQ cycle of channel 0 at position 1.
      rf_mask = 4'b0101;
      for (int k = 1; k <= 40; k++) begin
         start    = (k == 1);
         abort    = (k == 34);
         stp_tick = (k % 5 == 0);
         step();
         if (k < 34) chk($sformatf("abort k=%0d", k), obs, exp_at(0, k));
         else        chk($sformatf("abort k=%0d", k), obs, idle_at(1, 1'b0));
      end
      start    = 1'b0;
      abort    = 1'b0;
      stp_tick = 1'b0;

      // Mask is latched at start; later mask changes do not matter.
      rf_mask = 4'b1000;
      for (int k = 1; k <= 47; k++) begin
         start    = (k == 1);
         stp_tick = (k % 5 == 0);
         if (k >= 3) rf_mask = 4'b0001;
         step();
         chk($sformatf("mask k=%0d", k), obs, exp_at(1, k));
      end
      start    = 1'b0;
      stp_tick = 1'b0;

      // Asynchronous reset in the middle of a rotation.
      rf_mask = 4'b0101;
      for (int k = 1; k <= 17; k++) begin
         start    = (k == 1);
         stp_tick = (k % 5 == 0);
         step();
         chk($sformatf("prerst k=%0d", k), obs, exp_at(0, k));
      end
      start    = 1'b0;
      stp_tick = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_reset_mid_rotate", obs, IDLE_P0);
      #3 rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         stp_tick = (k % 2 == 0);
         step();
         chk($sformatf("post_rst k=%0d", k), obs, IDLE_P0);
      end
      stp_tick = 1'b0;

      // Rotation with no steps: watchdog trips, or the FSM waits and is aborted.
      rf_mask = 4'b0001;
      for (int k = 1; k <= 33; k++) begin
         logic [18:0] e;
         start = (k == 1);
`ifdef CMB_SEQ_WDOG_EN
         if (k == 32) start = 1'b1;
`else
         abort = (k == 32);
`endif
         step();
         if (k < 10)      e = exp_at(2, k);
         else if (k < 30) e = {1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
`ifdef CMB_SEQ_WDOG_EN
         else if (k < 32) e = idle_at(0, 1'b1);
         else             e = {1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
`else
         else if (k < 32) e = {1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
         else             e = idle_at(0, 1'b0);
`endif
         chk($sformatf("stall k=%0d", k), obs, e);
      end
      start = 1'b0;
      abort = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/scan_seq_ctrl.md
# scan_seq_ctrl

Scan sequencer for the CMB control board. It steps the rotation stage through N_POS angular positions. At each position it waits for mechanical settling, then walks the RF switch through every enabled channel and opens one ADC acquisition window per channel. It sits between the pushbutton/trigger conditioning and the stepper/RF/ADC output gating, and replaces ad-hoc enable toggling with one deterministic state machine.

## Interface
Parameters:
- N_POS, 400: positions per scan, 1..1023.
- STEPS_PER_POS, 8: stp_tick pulses per position advance, 1..255.
- SETTLE_CYC, 50000: clk50 cycles of settle after each rotation and before the first acquisition, ≥1.
- SW_CYC, 500: clk50 cycles of RF switch settle after each channel change, ≥1.
- ADC_CYC, 1000: clk50 cycles adc_en stays high per channel, ≥1.
- WDOG_CYC, 2000000: rotation watchdog limit in clk50 cycles (used only with CMB_SEQ_WDOG_EN).

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle scan request, already debounced and synchronous to clk50.
- abort  in  1  single-cycle abort request, synchronous.
- stp_tick  in  1  single-cycle pulse per stepper step, synchronous to clk50.
- rf_mask  in  4  enabled RF channels; bit i = channel i.
- rot_en  out  1  gates the stepper clock.
- rf_sw  out  4  one-hot RF switch select; 0 = all off.
- adc_en  out  1  ADC trigger gate.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on scan completion.
- fault  out  1  watchdog fault flag, sticky until the next accepted start.
- pos_count  out  10  current position index.

## Operation
- All outputs are registered (Moore). Reset values: rot_en=0, rf_sw=0, adc_en=0, busy=0, done=0, fault=0, pos_count=0; FSM enters IDLE.
- States: IDLE, SETTLE, RF_SEL, ACQ, ROTATE, DONE.
- IDLE:
  - start is accepted only if rf_mask≠0.
  - On accept: latch rf_mask into mask_q, clear pos_count and fault, go to SETTLE.
  - start with rf_mask=0 is ignored, as is start while busy.
- SETTLE: count SETTLE_CYC cycles, then go to RF_SEL with ch = lowest set bit of mask_q.
- RF_SEL: rf_sw = one-hot(ch). Hold SW_CYC cycles, then go to ACQ.
- ACQ:
  - adc_en=1 for exactly ADC_CYC cycles; rf_sw is held.
  - Then, if a higher enabled channel exists in mask_q, go to RF_SEL with that channel.
  - Otherwise rf_sw=0 and:
    - pos_count=N_POS−1 → DONE;
    - else → ROTATE.
- ROTATE:
  - rot_en=1; count stp_tick pulses.
  - On the STEPS_PER_POS-th tick: rot_en=0, pos_count+1, go to SETTLE.
  - Ticks arriving outside ROTATE are ignored.
- DONE: done=1 for one cycle, then IDLE. pos_count holds N_POS−1 until the next start.
- abort in any non-IDLE state:
  - next cycle is IDLE with rot_en, rf_sw and adc_en all 0;
  - pos_count holds its value; no done pulse.
  - abort in IDLE is a no-op.
  - abort has priority over any same-cycle transition.
- Reset mid-scan: all outputs go to their reset values immediately (asynchronously).
- Simultaneous start and abort in IDLE: start is accepted.

## Timing
- start at edge t → busy=1 at t+1, SETTLE begins.
- The first rf_sw is asserted SETTLE_CYC cycles after busy rises.
- Per channel: SW_CYC cycles with rf_sw set and adc_en=0, then ADC_CYC cycles with adc_en=1. adc_en falls on the same edge that rf_sw changes or clears.
- rf_sw is never changed while adc_en=1.
- rf_sw is never nonzero while rot_en=1.
- rot_en falls on the edge after the final stp_tick.
- done and busy fall on the same edge.
- Counters are wide enough for the maximum parameter values. Counters reload on every state entry.

## Configuration
- CMB_SEQ_WDOG_EN defined:
  - In ROTATE, a cycle counter resets on each stp_tick.
  - If the counter reaches WDOG_CYC, the FSM goes to IDLE with fault=1 (sticky), all outputs off, and no done pulse.
- Undefined: no watchdog logic is generated, fault is tied to 0, and WDOG_CYC is unused.

## Test plan
Parameters for the bench: N_POS=3, STEPS_PER_POS=2, SETTLE_CYC=4, SW_CYC=2, ADC_CYC=3.
- Full scan: rf_mask=4'b0101, start, stp_tick every 5 cycles → per position rf_sw 0001 then 0100, each followed by a 3-cycle adc_en; 6 acquisitions total; pos_count 0→1→2; one done pulse; busy falls with done.
- Rejected starts: rf_mask=0 then start → busy stays 0. start during a scan → no effect on sequence timing.
- Abort during ACQ at pos 1 → next cycle rot_en=0, rf_sw=0, adc_en=0, busy=0, pos_count=1, no done.
- Async reset asserted mid-ROTATE between clock edges → all outputs 0 immediately. After release, the FSM sits in IDLE until start.
- Mask latch: start with rf_mask=4'b1000, then change rf_mask to 4'b0001 mid-scan → only rf_sw=1000 is ever driven.
- With CMB_SEQ_WDOG_EN and WDOG_CYC=20: no stp_tick in ROTATE → IDLE and fault=1 after 20 cycles. The next start clears fault.
